naneye_config_tx: RTL and testbench
===================================

// Module: naneye_config_tx
// PURPOSE
//  Sensor-side configuration transmitter: the outbound counterpart of RX_DECODER/RX_DESERIALIZER.
//  On the decoder's CONFIG_EN pulse, takes config words over a valid/ready stream and serializes them MSB first.
//  Words are Manchester-encoded onto the shared sensor data line, with an output enable for the bidirectional pad.
//  Pulses CONFIG_DONE, which feeds the decoder's CONFIG_DONE input, when the line is handed back.
// PARAMETERS
//  HALF_BIT_CYCLES  4   SCLOCK cycles per Manchester half-bit (>=2)
//  WORD_BITS        16  data bits per config word
//  GUARD_BITS       2   idle-low bit periods driven after the last word, before release
// PORTS
//  SCLOCK       in   1          sample clock (PLL, 200 MHz); only clock
//  RESET        in   1          synchronous, active-high reset
//  ENABLE       in   1          module enable; low = synchronous abort to IDLE
//  CONFIG_EN    in   1          1-cycle pulse from the decoder: config window open
//  CFG_DATA     in   WORD_BITS  config word
//  CFG_VALID    in   1          CFG_DATA valid
//  CFG_LAST     in   1          qualifies CFG_DATA as the final word of the burst
//  CFG_READY    out  1          word accepted when CFG_VALID & CFG_READY
//  TX_DATA      out  1          Manchester serial output
//  TX_OE        out  1          pad output enable (1 = FPGA drives line)
//  BUSY         out  1          high in any state other than IDLE
//  CONFIG_DONE  out  1          1-cycle pulse: burst complete, line released
//  ERROR_OUT    out  1          1-cycle pulse: underrun abort
// BEHAVIOUR
//  Reset, and every cycle with ENABLE low: state IDLE; all outputs 0; counters cleared.
//  ENABLE low or RESET mid-burst: TX_OE=0 at the next edge. No CONFIG_DONE or ERROR_OUT pulse is issued.
//  Encoding, by bit value:
//   - '1': TX_DATA=1 for HALF_BIT_CYCLES, then 0 for HALF_BIT_CYCLES.
//   - '0': the inverse (0 then 1).
//   - Bit period = 2*HALF_BIT_CYCLES.
//  Word frame: start bit '1', then CFG_DATA[WORD_BITS-1:0] MSB first. Frame length = (WORD_BITS+1) bit periods.
//  State machine:
//   - IDLE: on CONFIG_EN & ENABLE -> LOAD. CONFIG_EN in any other state is ignored.
//   - LOAD: CFG_READY=1 (combinational from state); lasts exactly 1 cycle. Outcome by condition:
//     - CFG_VALID=1: latch shift register and CFG_LAST -> SHIFT.
//     - CFG_VALID=0, first word of burst: CONFIG_DONE pulse, TX_OE stays 0 -> IDLE.
//     - CFG_VALID=0, later word: ERROR_OUT pulse, TX_OE=0 -> IDLE.
//   - SHIFT: TX_OE=1. Half-bit timer and bit counter advance until the last half-bit of the last bit ends.
//     Then -> GUARD if the latched LAST=1, else -> LOAD.
//   - GUARD: TX_DATA=0, TX_OE=1 for GUARD_BITS*2*HALF_BIT_CYCLES cycles. Then TX_OE=0, CONFIG_DONE=1 for 1 cycle -> IDLE.
//  Latency and timing:
//   - CONFIG_EN at edge n puts LOAD at n+1; the first start half-bit (TX_DATA=1, TX_OE=1) appears at n+2.
//   - The LOAD cycle between words holds TX_DATA at its last value, stretching the final half-bit by exactly 1 cycle.
//  TX_DATA and TX_OE are registered outputs (no glitches). TX_DATA=0 whenever TX_OE=0.
//  Counter widths: half-bit $clog2(HALF_BIT_CYCLES); bit $clog2(WORD_BITS+2); guard $clog2(GUARD_BITS*2*HALF_BIT_CYCLES+1).
//  Each counter is cleared on entry to its state and wraps only via its state transition.
//  Simultaneous events:
//   - RESET wins over ENABLE, and ENABLE low wins over CONFIG_EN.
//   - A CONFIG_EN arriving in the same cycle as the GUARD->IDLE transition is ignored.
// STRUCTURE
//  naneye_defs.vh (shared with the RX side):
//   - state encodings IDLE/LOAD/SHIFT/GUARD;
//   - Manchester polarity constant MANCH_ONE_FIRST_HALF=1;
//   - start-bit value.
//  Sub-module naneye_manchester_enc: half-bit timer plus bit-to-level mapping.
//   - Inputs: bit value, bit_start.
//   - Outputs: TX level, bit_end strobe.
//  Top level holds the FSM, shift register, bit/guard counters and the stream handshake.
// TESTING (HALF_BIT_CYCLES=4, WORD_BITS=16, GUARD_BITS=2)
//  1. Single word 0xA5C3, LAST=1, CONFIG_EN at cycle 0:
//     - READY at cycle 1; TX_OE rises at cycle 2;
//     - TX_DATA pattern = start '1' then 1010_0101_1100_0011, each bit 8 cycles, as high/low half-bits;
//     - 136 cycles of data, then 16 cycles of 0;
//     - TX_OE falls and CONFIG_DONE pulses at cycle 154.
//  2. Two words 0x0001 then 0xFFFF (LAST on the 2nd):
//     - exactly 1 held cycle between frames;
//     - the second READY falls 137 cycles after the first;
//     - CONFIG_DONE pulses once.
//  3. Underrun: 1st word has LAST=0 and VALID is low at the 2nd LOAD -> ERROR_OUT 1-cycle pulse, TX_OE=0 next cycle, no CONFIG_DONE.
//  4. CONFIG_EN with VALID=0 -> CONFIG_DONE pulses at cycle 2; TX_OE never rises.
//  5. RESET high at cycle 50 of a frame -> all outputs 0 at the next edge. A new CONFIG_EN then transmits normally.
//  6. CONFIG_EN repeated mid-frame and ENABLE toggled low for 1 cycle:
//     - the repeat CONFIG_EN is ignored;
//     - the ENABLE low cycle aborts silently to IDLE.

Source files
------------

// File: rtl/naneye_config_tx_pkg.sv
// Shared definitions for the NanEye configuration transmitter: FSM encoding,
// Manchester polarity and start-bit value.
package naneye_config_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  localparam logic MANCH_ONE_FIRST_HALF = 1'b1;
  localparam logic START_BIT            = 1'b1;

  // Line level during the first half of a bit; the second half is its inverse.
  function automatic logic manch_first_half(input logic bit_val);
    return MANCH_ONE_FIRST_HALF ? bit_val : ~bit_val;
  endfunction

endpackage

// File: rtl/naneye_config_tx_enc.sv
// Manchester bit encoder: half-bit timer plus bit-to-level mapping.
// The level is a flop so it can drive the pad directly.
module naneye_config_tx_enc
  import naneye_config_tx_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic bit_start,
  input  logic bit_val,
  output logic level,
  output logic bit_end
);

  localparam int HALF_W = $clog2(HALF_BIT_CYCLES);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_BIT_CYCLES - 1);

  logic [HALF_W-1:0] half_cnt_r;
  logic              phase_r;
  logic              active_r;

  assign bit_end = active_r & phase_r & (half_cnt_r == HALF_LAST);

  // Half-bit timer; the level is held once a bit ends without a successor.
  always_ff @(posedge clk) begin
    if (clear) begin
      half_cnt_r <= '0;
      phase_r    <= 1'b0;
      active_r   <= 1'b0;
      level      <= 1'b0;
    end else if (bit_start) begin
      half_cnt_r <= '0;
      phase_r    <= 1'b0;
      active_r   <= 1'b1;
      level      <= manch_first_half(bit_val);
    end else if (active_r) begin
      if (half_cnt_r == HALF_LAST) begin
        half_cnt_r <= '0;
        if (!phase_r) begin
          phase_r <= 1'b1;
          level   <= ~level;
        end else begin
          phase_r  <= 1'b0;
          active_r <= 1'b0;
        end
      end else begin
        half_cnt_r <= half_cnt_r + HALF_W'(1);
      end
    end else begin
      half_cnt_r <= half_cnt_r;
    end
  end

endmodule

// File: rtl/naneye_config_tx.sv
// Sensor-side configuration transmitter: accepts config words on a valid/ready
// stream and sends them Manchester-encoded, MSB first, on the shared data line.
module naneye_config_tx
  import naneye_config_tx_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 4,
  parameter int WORD_BITS       = 16,
  parameter int GUARD_BITS      = 2
) (
  input  logic                 SCLOCK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic                 CONFIG_EN,
  input  logic [WORD_BITS-1:0] CFG_DATA,
  input  logic                 CFG_VALID,
  input  logic                 CFG_LAST,
  output logic                 CFG_READY,
  output logic                 TX_DATA,
  output logic                 TX_OE,
  output logic                 BUSY,
  output logic                 CONFIG_DONE,
  output logic                 ERROR_OUT
);

  localparam int BIT_W     = $clog2(WORD_BITS + 2);
  localparam int GUARD_LEN = GUARD_BITS * 2 * HALF_BIT_CYCLES;
  localparam int GUARD_W   = $clog2(GUARD_LEN + 1);
  localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(WORD_BITS);
  localparam logic [GUARD_W-1:0] GUARD_END = GUARD_W'(GUARD_LEN - 1);

  state_t                 state_r, state_nxt_s;
  logic [WORD_BITS-1:0]   shift_r, shift_nxt_s;
  logic                   last_r, last_nxt_s;
  logic                   first_r, first_nxt_s;
  logic [BIT_W-1:0]       bit_cnt_r, bit_cnt_nxt_s;
  logic [GUARD_W-1:0]     guard_cnt_r, guard_cnt_nxt_s;
  logic                   tx_oe_r, tx_oe_nxt_s;
  logic                   done_r, done_nxt_s;
  logic                   error_r, error_nxt_s;

  logic                   abort_s;
  logic                   enc_clear_s;
  logic                   bit_start_s;
  logic                   bit_val_s;
  logic                   enc_level_s;
  logic                   bit_end_s;

  naneye_config_tx_enc #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
  ) u_enc (
    .clk      (SCLOCK),
    .clear    (enc_clear_s),
    .bit_start(bit_start_s),
    .bit_val  (bit_val_s),
    .level    (enc_level_s),
    .bit_end  (bit_end_s)
  );

  assign abort_s     = RESET | ~ENABLE;
  assign CFG_READY   = (state_r == ST_LOAD) & ~abort_s;
  assign TX_DATA     = enc_level_s;
  assign TX_OE       = tx_oe_r;
  assign BUSY        = (state_r != ST_IDLE);
  assign CONFIG_DONE = done_r;
  assign ERROR_OUT   = error_r;

  // State, datapath and registered-output update.
  always_ff @(posedge SCLOCK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      shift_r     <= '0;
      last_r      <= 1'b0;
      first_r     <= 1'b0;
      bit_cnt_r   <= '0;
      guard_cnt_r <= '0;
      tx_oe_r     <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shift_r     <= shift_nxt_s;
      last_r      <= last_nxt_s;
      first_r     <= first_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      guard_cnt_r <= guard_cnt_nxt_s;
      tx_oe_r     <= tx_oe_nxt_s;
      done_r      <= done_nxt_s;
      error_r     <= error_nxt_s;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so they can be flopped.
  always_comb begin
    state_nxt_s     = state_r;
    shift_nxt_s     = shift_r;
    last_nxt_s      = last_r;
    first_nxt_s     = first_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    guard_cnt_nxt_s = guard_cnt_r;
    tx_oe_nxt_s     = 1'b0;
    done_nxt_s      = 1'b0;
    error_nxt_s     = 1'b0;
    enc_clear_s     = 1'b0;
    bit_start_s     = 1'b0;
    bit_val_s       = START_BIT;

    if (abort_s) begin
      state_nxt_s     = ST_IDLE;
      bit_cnt_nxt_s   = '0;
      guard_cnt_nxt_s = '0;
      first_nxt_s     = 1'b0;
      enc_clear_s     = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          enc_clear_s     = 1'b1;
          bit_cnt_nxt_s   = '0;
          guard_cnt_nxt_s = '0;
          if (CONFIG_EN) begin
            state_nxt_s = ST_LOAD;
            first_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (CFG_VALID) begin
            state_nxt_s   = ST_SHIFT;
            shift_nxt_s   = CFG_DATA;
            last_nxt_s    = CFG_LAST;
            first_nxt_s   = 1'b0;
            bit_cnt_nxt_s = '0;
            bit_start_s   = 1'b1;
            bit_val_s     = START_BIT;
            tx_oe_nxt_s   = 1'b1;
          end else begin
            // An empty burst is a clean handback; a missing later word is an underrun.
            state_nxt_s = ST_IDLE;
            enc_clear_s = 1'b1;
            done_nxt_s  = first_r;
            error_nxt_s = ~first_r;
          end
        end
        ST_SHIFT: begin
          tx_oe_nxt_s = 1'b1;
          if (bit_end_s) begin
            if (bit_cnt_r == LAST_BIT) begin
              if (last_r) begin
                state_nxt_s     = ST_GUARD;
                guard_cnt_nxt_s = '0;
                enc_clear_s     = 1'b1;
              end else begin
                state_nxt_s = ST_LOAD;
              end
            end else begin
              bit_start_s   = 1'b1;
              bit_val_s     = shift_r[WORD_BITS-1];
              shift_nxt_s   = {shift_r[WORD_BITS-2:0], 1'b0};
              bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
            end
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end
        ST_GUARD: begin
          enc_clear_s = 1'b1;
          if (guard_cnt_r == GUARD_END) begin
            state_nxt_s = ST_IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            tx_oe_nxt_s     = 1'b1;
            guard_cnt_nxt_s = guard_cnt_r + GUARD_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          enc_clear_s = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_naneye_config_tx.sv
// Self-checking bench for naneye_config_tx: a frame-level reference model builds
// per-cycle expected outputs which are compared against the DUT in each scenario.
module tb_naneye_config_tx;

  localparam int H    = 4;
  localparam int W    = 16;
  localparam int G    = 2;
  localparam int NMAX = 600;

  logic         SCLOCK = 1'b0;
  logic         RESET;
  logic         ENABLE;
  logic         CONFIG_EN;
  logic [W-1:0] CFG_DATA;
  logic         CFG_VALID;
  logic         CFG_LAST;
  logic         CFG_READY;
  logic         TX_DATA;
  logic         TX_OE;
  logic         BUSY;
  logic         CONFIG_DONE;
  logic         ERROR_OUT;

  naneye_config_tx #(
    .HALF_BIT_CYCLES(H),
    .WORD_BITS      (W),
    .GUARD_BITS     (G)
  ) dut (
    .SCLOCK     (SCLOCK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .CONFIG_EN  (CONFIG_EN),
    .CFG_DATA   (CFG_DATA),
    .CFG_VALID  (CFG_VALID),
    .CFG_LAST   (CFG_LAST),
    .CFG_READY  (CFG_READY),
    .TX_DATA    (TX_DATA),
    .TX_OE      (TX_OE),
    .BUSY       (BUSY),
    .CONFIG_DONE(CONFIG_DONE),
    .ERROR_OUT  (ERROR_OUT)
  );

  always #5 SCLOCK = ~SCLOCK;

  // Per-cycle stimulus; outputs packed as {READY, OE, DATA, BUSY, DONE, ERR}.
  logic         s_cen[NMAX];
  logic         s_valid[NMAX];
  logic [W-1:0] s_data[NMAX];
  logic         s_last[NMAX];
  logic         s_en[NMAX];
  logic         s_rst[NMAX];
  logic [5:0]   e_vec[NMAX];
  logic [5:0]   o_vec[NMAX];
  logic [W-1:0] w_data[4];
  logic         w_last[4];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic clear_arrays;
    for (int k = 0; k < NMAX; k++) begin
      s_cen[k]   = 1'b0;
      s_valid[k] = 1'($urandom_range(0, 1));
      s_data[k]  = W'($urandom);
      s_last[k]  = 1'($urandom_range(0, 1));
      s_en[k]    = 1'b1;
      s_rst[k]   = 1'b0;
      e_vec[k]   = 6'b000000;
    end
  endtask

  // Frame-level model: LOAD cycle, 17 Manchester bits, guard, then handback.
  task automatic model_burst(input int c0, input int n_words, input int n_avail,
                             output int c_end);
    int           c;
    int           idx;
    logic         first;
    logic         lvl;
    logic         fin;
    logic [W:0]   frame;
    c = c0; idx = 0; first = 1'b1; lvl = 1'b0; fin = 1'b0;
    s_cen[c] = 1'b1;
    c++;
    while (!fin) begin
      e_vec[c]   = {1'b1, ~first, (first ? 1'b0 : lvl), 1'b1, 2'b00};
      s_valid[c] = (idx < n_avail);
      if (idx < n_words) begin
        s_data[c] = w_data[idx];
        s_last[c] = w_last[idx];
      end
      c++;
      if (idx >= n_avail) begin
        e_vec[c] = first ? 6'b000010 : 6'b000001;
        fin = 1'b1;
      end else begin
        frame = {1'b1, w_data[idx]};
        for (int b = W; b >= 0; b--) begin
          for (int h = 0; h < 2 * H; h++) begin
            e_vec[c] = {2'b01, ((h < H) ? frame[b] : ~frame[b]), 3'b100};
            c++;
          end
        end
        lvl = ~frame[0];
        if (w_last[idx]) begin
          for (int g = 0; g < G * 2 * H; g++) begin
            e_vec[c] = 6'b010100;
            c++;
          end
          e_vec[c] = 6'b000010;
          fin = 1'b1;
        end else begin
          idx++;
          first = 1'b0;
        end
      end
    end
    c_end = c;
  endtask

  // Abort during cycle a: READY drops at once, everything else is idle from a+1.
  task automatic model_abort(input int a);
    e_vec[a][5] = 1'b0;
    for (int k = a + 1; k < NMAX; k++) e_vec[k] = 6'b000000;
  endtask

  task automatic play(input int n);
    for (int k = 0; k < n; k++) begin
      CONFIG_EN = s_cen[k];
      CFG_VALID = s_valid[k];
      CFG_DATA  = s_data[k];
      CFG_LAST  = s_last[k];
      ENABLE    = s_en[k];
      RESET     = s_rst[k];
      #1;
      o_vec[k] = {CFG_READY, TX_OE, TX_DATA, BUSY, CONFIG_DONE, ERROR_OUT};
      @(posedge SCLOCK);
      #1;
    end
    CONFIG_EN = 1'b0; CFG_VALID = 1'b0; ENABLE = 1'b1; RESET = 1'b0;
  endtask

  task automatic test_reset;
    logic [5:0] obs;
    RESET = 1'b1; ENABLE = 1'b1; CONFIG_EN = 1'b1; CFG_VALID = 1'b1;
    CFG_DATA = W'($urandom); CFG_LAST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge SCLOCK);
      #1;
      if (i == 3) begin
        RESET = 1'b0; CONFIG_EN = 1'b0; CFG_VALID = 1'b0;
        #1;
      end
      obs = {CFG_READY, TX_OE, TX_DATA, BUSY, CONFIG_DONE, ERROR_OUT};
      n_checks++;
      if (obs !== 6'b000000) $display("FAIL reset cycle %0d got %b want %b", i, obs, 6'b000000);
      else n_pass++;
    end
  endtask

  task automatic test_single_word;
    int         c_end;
    int         n;
    logic [16:0] pat;
    pat = 17'b1_1010_0101_1100_0011;
    clear_arrays();
    w_data[0] = 16'hA5C3; w_last[0] = 1'b1;
    model_burst(0, 1, 1, c_end);
    s_cen[153] = 1'b1;
    n = c_end + 6;
    play(n);
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (o_vec[k] !== e_vec[k]) $display("FAIL single_word cycle %0d got %b want %b", k, o_vec[k], e_vec[k]);
      else n_pass++;
    end
    n_checks++;
    if (o_vec[1][5] !== 1'b1) $display("FAIL single_ready1 got %b want 1", o_vec[1][5]);
    else n_pass++;
    n_checks++;
    if (o_vec[2][4] !== 1'b1 || o_vec[1][4] !== 1'b0) $display("FAIL single_oe_rise got %b%b want 01", o_vec[1][4], o_vec[2][4]);
    else n_pass++;
    for (int b = 0; b < 17; b++) begin
      n_checks++;
      if (o_vec[2 + 8 * b][3] !== pat[16 - b] || o_vec[6 + 8 * b][3] !== ~pat[16 - b])
        $display("FAIL single_bit %0d got %b%b want %b%b", b, o_vec[2 + 8 * b][3], o_vec[6 + 8 * b][3], pat[16 - b], ~pat[16 - b]);
      else n_pass++;
    end
    n_checks++;
    if (o_vec[154] !== 6'b000010 || o_vec[153][4] !== 1'b1) $display("FAIL single_done154 got %b want 000010", o_vec[154]);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int c_end;
    int n;
    int r0;
    int r1;
    int nr;
    int nd;
    clear_arrays();
    w_data[0] = 16'h0001; w_last[0] = 1'b0;
    w_data[1] = 16'hFFFF; w_last[1] = 1'b1;
    model_burst(0, 2, 2, c_end);
    n = c_end + 6;
    play(n);
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (o_vec[k] !== e_vec[k]) $display("FAIL back_to_back cycle %0d got %b want %b", k, o_vec[k], e_vec[k]);
      else n_pass++;
    end
    r0 = -1; r1 = -1; nr = 0; nd = 0;
    for (int k = 0; k < n; k++) begin
      if (o_vec[k][5] === 1'b1) begin
        if (nr == 0) r0 = k;
        else r1 = k;
        nr++;
      end
      if (o_vec[k][1] === 1'b1) nd++;
    end
    n_checks++;
    if (nr !== 2 || (r1 - r0) !== 137) $display("FAIL b2b_ready_gap got %0d readies gap %0d want 2 gap 137", nr, r1 - r0);
    else n_pass++;
    n_checks++;
    if (nd !== 1) $display("FAIL b2b_done_count got %0d want 1", nd);
    else n_pass++;
    n_checks++;
    if (o_vec[138] !== 6'b110100 || o_vec[137][3] !== 1'b0) $display("FAIL b2b_held_cycle got %b want 110100", o_vec[138]);
    else n_pass++;
  endtask

  task automatic test_underrun;
    int c_end;
    int n;
    int nd;
    clear_arrays();
    w_data[0] = W'($urandom); w_last[0] = 1'b0;
    model_burst(0, 1, 1, c_end);
    n = c_end + 6;
    play(n);
    nd = 0;
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (o_vec[k] !== e_vec[k]) $display("FAIL underrun cycle %0d got %b want %b", k, o_vec[k], e_vec[k]);
      else n_pass++;
      if (o_vec[k][1] === 1'b1) nd++;
    end
    n_checks++;
    if (o_vec[139] !== 6'b000001 || o_vec[140] !== 6'b000000 || nd !== 0)
      $display("FAIL underrun_pulse got %b %b done %0d want 000001 000000 done 0", o_vec[139], o_vec[140], nd);
    else n_pass++;
  endtask

  task automatic test_empty_burst;
    int c_end;
    int n;
    int noe;
    clear_arrays();
    w_data[0] = W'($urandom); w_last[0] = 1'b1;
    model_burst(0, 1, 0, c_end);
    n = c_end + 6;
    play(n);
    noe = 0;
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (o_vec[k] !== e_vec[k]) $display("FAIL empty_burst cycle %0d got %b want %b", k, o_vec[k], e_vec[k]);
      else n_pass++;
      if (o_vec[k][4] === 1'b1) noe++;
    end
    n_checks++;
    if (o_vec[2] !== 6'b000010 || noe !== 0) $display("FAIL empty_done2 got %b oe_cycles %0d want 000010 0", o_vec[2], noe);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int c_end;
    int n;
    clear_arrays();
    w_data[0] = W'($urandom); w_last[0] = 1'b1;
    model_burst(0, 1, 1, c_end);
    s_rst[52] = 1'b1;
    model_abort(52);
    w_data[0] = W'($urandom);
    model_burst(60, 1, 1, c_end);
    n = c_end + 6;
    play(n);
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (o_vec[k] !== e_vec[k]) $display("FAIL reset_mid cycle %0d got %b want %b", k, o_vec[k], e_vec[k]);
      else n_pass++;
    end
    n_checks++;
    if (o_vec[53] !== 6'b000000) $display("FAIL reset_mid_clear got %b want 000000", o_vec[53]);
    else n_pass++;
  endtask

  task automatic test_cfg_en_enable;
    int c_end;
    int n;
    int np;
    clear_arrays();
    w_data[0] = W'($urandom); w_last[0] = 1'b0;
    w_data[1] = W'($urandom); w_last[1] = 1'b1;
    model_burst(0, 2, 2, c_end);
    s_cen[40] = 1'b1;
    s_en[80]  = 1'b0;
    model_abort(80);
    s_cen[90] = 1'b1;
    s_en[90]  = 1'b0;
    model_burst(100, 2, 2, c_end);
    n = c_end + 6;
    play(n);
    np = 0;
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (o_vec[k] !== e_vec[k]) $display("FAIL cfg_en_enable cycle %0d got %b want %b", k, o_vec[k], e_vec[k]);
      else n_pass++;
      if (k < 100 && (o_vec[k][1] === 1'b1 || o_vec[k][0] === 1'b1)) np++;
    end
    n_checks++;
    if (o_vec[81] !== 6'b000000 || np !== 0) $display("FAIL silent_abort got %b pulses %0d want 000000 0", o_vec[81], np);
    else n_pass++;
  endtask

  task automatic test_random;
    int c_end;
    int n;
    int nw;
    int na;
    for (int it = 0; it < 4; it++) begin
      clear_arrays();
      nw = $urandom_range(1, 3);
      na = $urandom_range(0, nw);
      for (int i = 0; i < 4; i++) begin
        w_data[i] = W'($urandom);
        w_last[i] = 1'($urandom_range(0, 3) == 0);
      end
      if (na == nw) w_last[nw - 1] = 1'b1;
      model_burst(0, nw, na, c_end);
      n = c_end + 6;
      play(n);
      for (int k = 0; k < n; k++) begin
        n_checks++;
        if (o_vec[k] !== e_vec[k]) $display("FAIL random it %0d cycle %0d got %b want %b", it, k, o_vec[k], e_vec[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_empty_burst();
    test_reset_mid_frame();
    test_cfg_en_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
